univ_reg: RTL and testbench

- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit universal register.
- Sync active-low clear/set, clock enable, and eight operating modes: hold, parallel load, shift, rotate, increment, decrement.
- Used as the general-purpose storage/shift/count element in datapaths, replacing banks of discrete flops.
- All state is updated on the rising edge of clk. Asynchronous reset returns it to a known value.

---
 rtl/univ_reg_if.sv | 27 ++
 rtl/univ_reg.sv | 88 ++++++++
 tb/tb_univ_reg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/univ_reg_if.sv
// Control, data and status bundle for the universal register.
// The master drives controls and data; the slave (the register) returns state and status.
interface univ_reg_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             clr_n;
    logic             set_n;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             sout;
    logic             zero;
    logic             wrap;

    modport master (
        output en, clr_n, set_n, mode, d, sin,
        input  q, qn, sout, zero, wrap
    );

    modport slave (
        input  en, clr_n, set_n, mode, d, sin,
        output q, qn, sout, zero, wrap
    );
endinterface

// File: rtl/univ_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate, increment and decrement,
// with synchronous clear/set and a one-cycle wrap pulse on counter roll-over.
module univ_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    univ_reg_if.slave   bus
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic             r_dir;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_dir_nxt;
    logic             w_wrap_nxt;

    // Clear beats set, and both override the clock enable.
    always_comb begin
        w_q_nxt    = r_q;
        w_dir_nxt  = r_dir;
        w_wrap_nxt = 1'b0;
        if (!bus.clr_n) begin
            w_q_nxt = '0;
        end else if (!bus.set_n) begin
            w_q_nxt = SET_VAL;
        end else if (bus.en) begin
            case (mode_e'(bus.mode))
                M_HOLD: w_q_nxt = r_q;
                M_LOAD: w_q_nxt = bus.d;
                M_SHL: begin
                    w_q_nxt   = {r_q[WIDTH-2:0], bus.sin};
                    w_dir_nxt = 1'b0;
                end
                M_SHR: begin
                    w_q_nxt   = {bus.sin, r_q[WIDTH-1:1]};
                    w_dir_nxt = 1'b1;
                end
                M_ROL: begin
                    w_q_nxt   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_dir_nxt = 1'b0;
                end
                M_ROR: begin
                    w_q_nxt   = {r_q[0], r_q[WIDTH-1:1]};
                    w_dir_nxt = 1'b1;
                end
                M_INC: begin
                    w_q_nxt    = r_q + WIDTH'(1);
                    w_wrap_nxt = &r_q;
                end
                M_DEC: begin
                    w_q_nxt    = r_q - WIDTH'(1);
                    w_wrap_nxt = ~|r_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q    <= RESET_VAL;
            r_dir  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_dir  <= w_dir_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.qn   = ~r_q;
    assign bus.zero = (r_q == '0);
    assign bus.sout = r_dir ? r_q[0] : r_q[WIDTH-1];
    assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg: table of vectors plus hand-written reset sequences,
// with expected results passed through a scoreboard queue.
module tb_univ_reg;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   clk_run = 1'b0;

    univ_reg_if #(.WIDTH(W)) bus ();

    univ_reg #(.WIDTH(W), .RESET_VAL(8'h00), .SET_VAL(8'hFF)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic       clr_n;
        logic       set_n;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] q;
        logic       wrap;
        logic       sout;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       wrap;
        logic       sout;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] q, input logic wrap, input logic sout, input string tag);
        exp_t e;
        e.q = q; e.wrap = wrap; e.sout = sout; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        n_tests--;
        e = sb.pop_front();
        check({e.tag, "_q"},    bus.q,            e.q);
        check({e.tag, "_qn"},   bus.qn,           ~e.q);
        check({e.tag, "_zero"}, {7'b0, bus.zero}, {7'b0, (e.q == 8'h00)});
        check({e.tag, "_sout"}, {7'b0, bus.sout}, {7'b0, e.sout});
        check({e.tag, "_wrap"}, {7'b0, bus.wrap}, {7'b0, e.wrap});
    endtask

    task automatic drive(input logic en, input logic clr_n, input logic set_n,
                         input logic [2:0] mode, input logic [7:0] d, input logic sin);
        bus.en = en; bus.clr_n = clr_n; bus.set_n = set_n;
        bus.mode = mode; bus.d = d; bus.sin = sin;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.en, v.clr_n, v.set_n, v.mode, v.d, v.sin);
        push_exp(v.q, v.wrap, v.sout, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    function automatic vec_t mk(input logic en, input logic clr_n, input logic set_n,
                                input logic [2:0] mode, input logic [7:0] d, input logic sin,
                                input logic [7:0] q, input logic wrap, input logic sout);
        vec_t v;
        v.en = en; v.clr_n = clr_n; v.set_n = set_n; v.mode = mode;
        v.d = d; v.sin = sin; v.q = q; v.wrap = wrap; v.sout = sout;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                en clr set mode    d      sin  q      wrap sout
        vecs.push_back(mk(1, 1, 1, 3'b001, 8'hA5, 0, 8'hA5, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b010, 8'h00, 1, 8'h4B, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b010, 8'h00, 1, 8'h97, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b001, 8'h81, 0, 8'h81, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b101, 8'h00, 0, 8'hC0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b100, 8'h00, 0, 8'h81, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b011, 8'h00, 0, 8'h40, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b001, 8'hFE, 0, 8'hFE, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b110, 8'h00, 0, 8'hFF, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b110, 8'h00, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 1, 1, 3'b111, 8'h00, 0, 8'hFF, 1, 1));
        vecs.push_back(mk(1, 1, 1, 3'b000, 8'h00, 0, 8'hFF, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3'b001, 8'h12, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b001, 8'h12, 0, 8'hFF, 0, 1));
        vecs.push_back(mk(0, 1, 1, 3'b110, 8'h12, 0, 8'hFF, 0, 1));
        vecs.push_back(mk(1, 0, 1, 3'b110, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 0, 3'b111, 8'h00, 0, 8'hFF, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b011, 8'h00, 1, 8'hFF, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b001, 8'h02, 0, 8'h02, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b011, 8'h00, 1, 8'h81, 0, 1));
        vecs.push_back(mk(1, 1, 1, 3'b010, 8'h00, 0, 8'h02, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b111, 8'h00, 0, 8'h01, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b111, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3'b111, 8'h00, 0, 8'hFF, 1, 1));
        vecs.push_back(mk(1, 1, 1, 3'b110, 8'h00, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 1, 1, 3'b000, 8'h00, 0, 8'h00, 0, 0));

        drive(0, 1, 1, 3'b000, 8'h00, 0);

        // Reset pulse with the clock idle.
        #3 rst = 1'b1;
        push_exp(8'h00, 0, 0, "rst_async");
        #1 pop_check();
        #2 rst = 1'b0;
        push_exp(8'h00, 0, 0, "rst_release");
        #1 pop_check();
        clk_run = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of an increment run; direction flag must also return to left.
        apply(mk(1, 1, 1, 3'b011, 8'h00, 1, 8'h80, 0, 0), "a_shr");
        apply(mk(1, 1, 1, 3'b001, 8'h37, 0, 8'h37, 0, 1), "a_load");
        apply(mk(1, 1, 1, 3'b110, 8'h00, 0, 8'h38, 0, 0), "a_inc");
        #3 rst = 1'b1;
        push_exp(8'h00, 0, 0, "a_rst_mid");
        #1 pop_check();
        @(posedge clk);
        #1;
        push_exp(8'h00, 0, 0, "a_rst_held");
        pop_check();
        #2 rst = 1'b0;
        push_exp(8'h00, 0, 0, "a_rst_rel");
        #1 pop_check();
        apply(mk(1, 1, 1, 3'b110, 8'h00, 0, 8'h01, 0, 0), "a_inc_after");

        // Reset must kill a pending wrap pulse at once.
        apply(mk(1, 1, 1, 3'b001, 8'hFF, 0, 8'hFF, 0, 1), "b_load");
        apply(mk(1, 1, 1, 3'b110, 8'h00, 0, 8'h00, 1, 0), "b_wrap");
        #3 rst = 1'b1;
        push_exp(8'h00, 0, 0, "b_rst_mid");
        #1 pop_check();
        #2 rst = 1'b0;
        apply(mk(1, 1, 1, 3'b000, 8'h00, 0, 8'h00, 0, 0), "b_hold");

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
